maj_exhaustive_checker: RTL
===========================

Name: maj_exhaustive_checker

Overview:
- Hardware counterpart of the mapped N-input majority netlists: drives the netlist's x inputs and consumes its y0 output.
- Sweeps all 2^N input vectors, one per clock, and compares y0 against an internal popcount-threshold reference.
- Reports pass/fail, a saturating mismatch count and the first failing vector, so mapped `top` netlists can be checked on FPGA/emulation instead of in long simulation.

Parameters:
- N, 31, input count of the majority DUT (x_out width)
- THRESH, (N+1)/2, reference is 1 when popcount(vector) >= THRESH
- DUT_LAT, 0, cycles from x_out change to the matching y_dut (0 = combinational DUT)
- CNT_W, 16, width of the saturating mismatch counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- stop_on_fail  input  1  end the sweep at the first mismatch; sampled with start and held for the sweep
- y_dut  input  1  DUT output (y0)
- x_out  output  N  vector driven to DUT x0..x(N-1); x_out[i] drives xi
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- pass  output  1  done && mismatch_cnt==0
- mismatch_cnt  output  CNT_W  saturating mismatch count
- first_fail_valid  output  1  first_fail_vec holds a captured vector
- first_fail_vec  output  N  vector of the first mismatch

Behaviour:
- Reset (rst=1 at an edge, from any state):
  - state=IDLE; x_out, mismatch_cnt and first_fail_vec = 0; busy, done, pass and first_fail_valid = 0.
  - Delay pipeline is flushed. Reset mid-sweep abandons the sweep with no result.
- States IDLE, RUN, DRAIN, DONE.
- IDLE/DONE --start=1--> RUN:
  - vector counter = 0; mismatch_cnt, first_fail_valid and first_fail_vec cleared; done drops.
  - start while busy is ignored.
- RUN:
  - x_out = counter, incrementing by 1 each cycle from 0 to 2^N-1. The counter is N+1 bits so the terminal value is detected without wrap.
  - After the cycle presenting 2^N-1: go to DRAIN if DUT_LAT>0, else DONE. x_out holds 2^N-1 through DRAIN and DONE.
- DRAIN: lasts exactly DUT_LAT cycles, then DONE.
- Reference alignment:
  - ref = (popcount(x_out) >= THRESH), combinational, popcount width clog2(N+1).
  - ref, the vector and a valid bit pass through a DUT_LAT-deep shift register (a wire when DUT_LAT=0).
  - A compare occurs in each cycle where the delayed valid is 1. Total compares per full sweep = exactly 2^N.
- Compare: mismatch when y_dut !== delayed ref. y_dut X/Z counts as a mismatch.
  - mismatch_cnt increments on a mismatch and saturates at 2^CNT_W-1.
  - On the first mismatch of a sweep: first_fail_vec = delayed vector, first_fail_valid=1. Later mismatches do not update either.
- stop_on_fail=1: the cycle after the first mismatch, state=DONE. In-flight pipeline entries are discarded, and mismatch_cnt=1.
- Timing:
  - The start edge is edge 0; vector v is presented in cycle v.
  - done rises at edge 2^N+DUT_LAT and stays high until the next start or rst.
  - busy is high for exactly 2^N+DUT_LAT cycles in a full sweep.
- start and rst in the same cycle: rst wins.
- The full N=31 sweep is 2^31 cycles. Benches use small N.

Test Plan:
- Golden DUT, N=3, THRESH=2, DUT_LAT=0, single-cycle start:
  - x_out steps 0..7, busy high 8 cycles, done at edge 8.
  - pass=1, mismatch_cnt=0, first_fail_valid=0.
- y_dut stuck-at-0, N=3, stop_on_fail=0: mismatches on vectors 3,5,6,7 -> mismatch_cnt=4, first_fail_vec=3'b011, pass=0.
- Golden DUT registered twice, N=3, DUT_LAT=2: busy high 10 cycles, done at edge 10, pass=1, compare count 8 (no compare against pipeline fill).
- Inverted DUT, stop_on_fail=1: fail on vector 0 -> done on the next edge, mismatch_cnt=1, first_fail_vec=0; a second start clears results and restarts at x_out=0.
- Inverted DUT, N=3, CNT_W=2: 8 mismatches -> mismatch_cnt saturates at 3, pass=0.
- rst asserted at vector 5 of an N=3 sweep: next edge all outputs 0, state IDLE; start while rst=1 ignored; the subsequent start runs a clean full sweep, pass=1.

Source files
------------

// File: rtl/maj_exhaustive_checker.sv
// Exhaustive checker for N-input majority netlists: sweeps every input vector,
// compares y_dut against a popcount-threshold reference, and reports the result.
module maj_exhaustive_checker #(
   parameter int unsigned N       = 31,
   parameter int unsigned THRESH  = (N + 1) / 2,
   parameter int unsigned DUT_LAT = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop_on_fail,
   input  logic             y_dut,
   output logic [N-1:0]     x_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic             first_fail_valid,
   output logic [N-1:0]     first_fail_vec
);

   localparam int unsigned PC_W     = $clog2(N + 1);
   localparam int unsigned DR_W     = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
   localparam int unsigned DR_LAST  = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;
   localparam logic [N:0]  LAST_VEC = {1'b0, {N{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [N:0]        cnt_q, cnt_d;
   logic [DR_W-1:0]   drain_q, drain_d;
   logic              stop_q, stop_d;
   logic [CNT_W-1:0]  mcnt_d;
   logic              ffv_d;
   logic [N-1:0]      ffvec_d;
   logic              flush_c;

   logic [PC_W-1:0]   pc_c;
   logic              ref_c;
   logic              run_c;
   logic              dly_valid;
   logic              dly_ref;
   logic [N-1:0]      dly_vec;
   logic              mismatch_c;

   // Reference value for the vector currently on x_out
   always_comb begin
      pc_c = '0;
      for (int i = 0; i < N; i++) pc_c = pc_c + PC_W'(x_out[i]);
   end
   assign ref_c = (32'(pc_c) >= THRESH);
   assign run_c = (state_q == S_RUN);

   // Align reference, vector and valid with the DUT's output latency
   generate
      if (DUT_LAT == 0) begin : g_nodly
         assign dly_valid = run_c;
         assign dly_ref   = ref_c;
         assign dly_vec   = x_out;
      end else begin : g_dly
         logic [DUT_LAT-1:0] vld_q;
         logic [DUT_LAT-1:0] ref_q;
         logic [N-1:0]       vec_q [DUT_LAT];

         always_ff @(posedge clk) begin
            if (rst || flush_c) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= run_c;
               for (int i = 1; i < DUT_LAT; i++) vld_q[i] <= vld_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            ref_q[0] <= ref_c;
            vec_q[0] <= x_out;
            for (int i = 1; i < DUT_LAT; i++) begin
               ref_q[i] <= ref_q[i-1];
               vec_q[i] <= vec_q[i-1];
            end
         end

         assign dly_valid = vld_q[DUT_LAT-1];
         assign dly_ref   = ref_q[DUT_LAT-1];
         assign dly_vec   = vec_q[DUT_LAT-1];
      end
   endgenerate

   // X or Z on y_dut must count as a failure, hence the case inequality
   assign mismatch_c = dly_valid && (y_dut !== dly_ref);

   // Next-state and result update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      stop_d  = stop_q;
      mcnt_d  = mismatch_cnt;
      ffv_d   = first_fail_valid;
      ffvec_d = first_fail_vec;
      flush_c = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               mcnt_d  = '0;
               ffv_d   = 1'b0;
               ffvec_d = '0;
               stop_d  = stop_on_fail;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST_VEC) begin
               state_d = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
               drain_d = '0;
            end else begin
               cnt_d = cnt_q + (N+1)'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == DR_W'(DR_LAST)) state_d = S_DONE;
            else                           drain_d = drain_q + DR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      if (mismatch_c && (state_q == S_RUN || state_q == S_DRAIN)) begin
         if (mismatch_cnt != CNT_MAX) mcnt_d = mismatch_cnt + CNT_W'(1);
         if (!first_fail_valid) begin
            ffv_d   = 1'b1;
            ffvec_d = dly_vec;
         end
         if (stop_q) begin
            state_d = S_DONE;
            flush_c = 1'b1;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         drain_q          <= '0;
         stop_q           <= 1'b0;
         x_out            <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         mismatch_cnt     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         drain_q          <= drain_d;
         stop_q           <= stop_d;
         x_out            <= cnt_d[N-1:0];
         busy             <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done             <= (state_d == S_DONE);
         pass             <= (state_d == S_DONE) && (mcnt_d == '0);
         mismatch_cnt     <= mcnt_d;
         first_fail_valid <= ffv_d;
         first_fail_vec   <= ffvec_d;
      end
   end

endmodule
